// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, opcode and funct3 values.
package lsu_pkg;
  localparam int WIDTH  = 32;
  localparam int SIZE   = 256;
  localparam int ADDR_W = $clog2(SIZE);

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, LD_WAIT, RESP} lsu_state_e;
endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a memory read word and sign/zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [WIDTH-1:0] i_rdata,
  input  logic [1:0]       i_off,
  input  logic [2:0]       i_funct3,
  output logic [WIDTH-1:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'b0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'b0, w_half};
      default: o_data = i_rdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: drives data memory in the accept cycle, aligns the
// returned word and reports faults through a one-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              illegal,
  output logic [1:0]        dbg_state
);
  // Handshake: a request transfers on a cycle where req_valid && req_ready; EX holds it until then.
  lsu_state_e  r_state, w_next;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic [31:0] r_load_data;
  logic        r_mis, r_ill;
  logic        w_is_ld, w_is_st, w_accept, w_illegal, w_misaligned, w_fault;
  logic [31:0] w_aligned;
  logic        w_unused;

  assign w_unused = ^addr[31:ADDR_W+2];

  always_comb begin
    w_is_ld      = (opcode == OP_LD);
    w_is_st      = (opcode == OP_ST);
    // reset gates acceptance so strobes stay low while reset is held
    w_accept     = reset && req_valid && (r_state == IDLE) && (w_is_ld || w_is_st);
    w_illegal    = w_is_ld ? (funct3 inside {3'b011, 3'b110, 3'b111}) : (funct3 > F3_SW);
    w_misaligned = !w_illegal &&
                   (((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
    w_fault      = w_illegal || w_misaligned;
  end

  assign mem_addr = addr[ADDR_W+1:2];
  assign mem_re   = w_accept && w_is_ld && !w_fault;
  assign mem_we   = w_accept && w_is_st && !w_fault;

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = store_data;
    case (funct3)
      F3_SB: begin
        mem_be    = 4'b0001 << addr[1:0];
        mem_wdata = {4{store_data[7:0]}};
      end
      F3_SH: begin
        mem_be    = addr[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{store_data[15:0]}};
      end
      F3_SW:   mem_be = 4'b1111;
      default: mem_be = 4'b0000;
    endcase
    if (!mem_we) mem_be = 4'b0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_is_ld && !w_fault) ? LD_WAIT : RESP;
      LD_WAIT: w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  load_align u_align (
    .i_rdata  (mem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_aligned)
  );

  // Response fields only change on the edge that enters RESP, so they hold between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_off       <= 2'b00;
      r_f3        <= 3'b000;
      r_load_data <= 32'b0;
      r_mis       <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_off <= addr[1:0];
        r_f3  <= funct3;
      end
      if (w_accept && (w_next == RESP)) begin
        r_load_data <= 32'b0;
        r_mis       <= w_misaligned;
        r_ill       <= w_illegal;
      end else if (r_state == LD_WAIT) begin
        r_load_data <= w_aligned;
        r_mis       <= 1'b0;
        r_ill       <= 1'b0;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign load_data  = r_load_data;
  assign misaligned = r_mis;
  assign illegal    = r_ill;
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a byte-addressed model.
module tb_load_store_unit;
  localparam logic [6:0] T_LD = 7'b0000011;
  localparam logic [6:0] T_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [7:0]  mem_addr;
  logic        mem_re, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'b0;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misaligned, illegal;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] init_w[256];
  logic [31:0] mem_w[256];
  logic        mem_loaded = 1'b0;
  logic [7:0]  refb[1024];

  logic        cap_re, cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata, cap_ld;
  logic [7:0]  cap_addr;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct3(funct3), .addr(addr), .store_data(store_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
    .load_data(load_data), .misaligned(misaligned), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT: byte-enabled writes, registered reads.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem_w[i] <= init_w[i];
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem_w[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_re) mem_rdata <= mem_w[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input int ba, input int size, input logic uns);
    logic [31:0] v;
    v = 32'b0;
    for (int k = 0; k < size; k++) v = v | ({24'b0, refb[ba + k]} << (8 * k));
    if (!uns && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  task automatic do_req(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    int n, size, ba;
    logic is_ld, is_st, ill, mis, fault;
    logic [31:0] exp_ld;
    logic [3:0]  exp_be;
    n = 0;
    while (!req_ready && n < 8) begin @(negedge clk); n++; end
    check("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; opcode = op; funct3 = f3; addr = a; store_data = d;
    #1;
    cap_re = mem_re; cap_we = mem_we; cap_be = mem_be; cap_wdata = mem_wdata; cap_addr = mem_addr;
    is_ld = (op == T_LD);
    is_st = (op == T_ST);
    if (!is_ld && !is_st) begin
      check("drop_re", {31'b0, mem_re}, 32'd0);
      check("drop_we", {31'b0, mem_we}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check("drop_resp", {31'b0, resp_valid}, 32'd0);
        check("drop_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
      end
      return;
    end
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill   = is_ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 > 3'd2);
    mis   = !ill && ((a & (size - 1)) != 0);
    fault = ill || mis;
    ba    = int'(a[9:0]);
    exp_ld = 32'b0;
    if (is_ld && !fault) exp_ld = model_load(ba, size, f3[2]);
    check("mem_re", {31'b0, cap_re}, {31'b0, is_ld && !fault});
    check("mem_we", {31'b0, cap_we}, {31'b0, is_st && !fault});
    if (!fault) check("mem_addr", {24'b0, cap_addr}, (a >> 2) & 32'hFF);
    if (is_st && !fault) begin
      exp_be = 4'b0;
      for (int k = 0; k < size; k++) exp_be[(ba + k) % 4] = 1'b1;
      check("mem_be", {28'b0, cap_be}, {28'b0, exp_be});
      for (int k = 0; k < size; k++) begin
        check("lane", (cap_wdata >> (8 * ((ba + k) % 4))) & 32'hFF, (d >> (8 * k)) & 32'hFF);
        refb[ba + k] = d[8*k +: 8];
      end
    end
    @(negedge clk);
    req_valid = 1'b0; opcode = 7'($urandom); addr = $urandom;
    if (is_ld && !fault) begin
      check("ld_wait_resp", {31'b0, resp_valid}, 32'd0);
      check("ld_wait_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    check("resp_valid", {31'b0, resp_valid}, 32'd1);
    check("load_data", load_data, exp_ld);
    check("misaligned", {31'b0, misaligned}, {31'b0, mis});
    check("illegal", {31'b0, illegal}, {31'b0, ill});
    cap_ld = load_data;
    @(negedge clk);
    check("resp_pulse", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      init_w[i] = w;
      for (int k = 0; k < 4; k++) refb[4*i + k] = w[8*k +: 8];
    end
    reset = 1'b0; req_valid = 1'b0; opcode = 7'b0; funct3 = 3'b0; addr = 32'b0; store_data = 32'b0;
    repeat (3) @(negedge clk);
    req_valid = 1'b1; opcode = T_LD; funct3 = 3'd2; #1;
    check("rst_resp", {31'b0, resp_valid}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_mis", {31'b0, misaligned}, 32'd0);
    check("rst_ill", {31'b0, illegal}, 32'd0);
    check("rst_re", {31'b0, mem_re}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    do_req(T_ST, 3'd0, 32'h0000_0005, 32'hAABB_CCDD);
    check("sb_addr", {24'b0, cap_addr}, 32'd1);
    check("sb_be", {28'b0, cap_be}, 32'h2);
    check("sb_wdata", cap_wdata, 32'hDDDD_DDDD);

    do_req(T_ST, 3'd2, 32'h0, 32'h8001_1234);
    do_req(T_ST, 3'd2, 32'h4, 32'h80A5_A5A5);
    do_req(T_LD, 3'd0, 32'h7, 32'h0); check("lb_neg", cap_ld, 32'hFFFF_FF80);
    do_req(T_LD, 3'd4, 32'h7, 32'h0); check("lbu", cap_ld, 32'h0000_0080);
    do_req(T_LD, 3'd1, 32'h2, 32'h0); check("lh_neg", cap_ld, 32'hFFFF_8001);
    do_req(T_LD, 3'd5, 32'h2, 32'h0); check("lhu", cap_ld, 32'h0000_8001);
    do_req(T_LD, 3'd2, 32'h4, 32'h0); check("lw", cap_ld, 32'h80A5_A5A5);
    do_req(T_LD, 3'd2, 32'h2, 32'h0); check("lw_mis_re", {31'b0, cap_re}, 32'd0);
    do_req(T_ST, 3'd1, 32'h1, 32'h1234_5678); check("sh_mis_we", {31'b0, cap_we}, 32'd0);
    do_req(T_LD, 3'd3, 32'h8, 32'h0);
    do_req(T_ST, 3'd5, 32'h8, 32'h0);
    do_req(7'b0110011, 3'd0, 32'h8, 32'h0);
    do_req(T_LD, 3'd2, 32'hFFFF_FC08, 32'h0);

    // Reset arriving while a load waits for memory must discard it.
    req_valid = 1'b1; opcode = T_LD; funct3 = 3'd2; addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b0; #1;
    check("mid_rst_resp", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_ld", load_data, 32'd0);
    req_valid = 1'b1; #1;
    check("mid_rst_re", {31'b0, mem_re}, 32'd0);
    @(negedge clk);
    check("mid_rst_resp2", {31'b0, resp_valid}, 32'd0);
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_resp", {31'b0, resp_valid}, 32'd0);
    check("post_rst_ld", load_data, 32'd0);
    check("post_rst_mis", {31'b0, misaligned}, 32'd0);
    check("post_rst_ill", {31'b0, illegal}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      op  = (sel < 5) ? T_LD : (sel < 9) ? T_ST : 7'($urandom);
      do_req(op, 3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
